// File: rtl/arbiter_router_burst_arbiter_if.sv
// arbiter_router_burst_arbiter_if: val/rdy bundle between NINPUTS request streams and one merged output stream.
// Ports: istream_val/msg/rdy (per input), ostream_val/msg/rdy (merged, msg = {source tag, payload}),
//        grant_idx (selected input), busy (burst locked). slave = arbiter side, master = driver side.
interface arbiter_router_burst_arbiter_if #(
    parameter int NBITS   = 16,
    parameter int NINPUTS = 4
);
    localparam int ADDR_NBITS = $clog2(NINPUTS);
    logic [NINPUTS-1:0]                  istream_val;
    logic [NINPUTS-1:0][NBITS-1:0]       istream_msg;
    logic [NINPUTS-1:0]                  istream_rdy;
    logic                                ostream_val;
    logic [ADDR_NBITS+NBITS-1:0]         ostream_msg;
    logic                                ostream_rdy;
    logic [ADDR_NBITS-1:0]               grant_idx;
    logic                                busy;
    modport slave (
        input  istream_val, istream_msg, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg, grant_idx, busy
    );
    modport master (
        output istream_val, istream_msg, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg, grant_idx, busy
    );
endinterface

// File: rtl/arbiter_router_burst_arbiter.sv
// arbiter_router_burst_arbiter: round-robin merge of NINPUTS val/rdy streams with the grant locked for BURST_LEN beats.
// Ports: clk, reset (async, active-low), io (slave modport: per-input streams in, tagged merged stream out,
//        grant_idx and busy status). Datapath is purely combinational; only arbitration state is stored.
module arbiter_router_burst_arbiter #(
    parameter int NBITS     = 16,
    parameter int NINPUTS   = 4,
    parameter int BURST_LEN = 8
) (
    input logic clk,
    input logic reset,
    arbiter_router_burst_arbiter_if.slave io
);
    localparam int ADDR_NBITS = $clog2(NINPUTS);
    localparam int CNT_NBITS  = $clog2(BURST_LEN + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t                state;
    logic [ADDR_NBITS-1:0] ptr, gnt, rr_sel, cand, sel, sel_nxt;
    logic [CNT_NBITS-1:0]  cnt;
    logic                  xfer;
    // Scan from the far end back toward ptr so the last hit is the first valid input at or after ptr.
    always_comb begin
        rr_sel = ptr;
        cand   = '0;
        for (int k = NINPUTS - 1; k >= 0; k--) begin
            cand = ADDR_NBITS'((int'(ptr) + k) % NINPUTS);
            if (io.istream_val[cand]) rr_sel = cand;
        end
    end
    assign sel     = (state == BURST) ? gnt : rr_sel;
    assign sel_nxt = (sel == ADDR_NBITS'(NINPUTS - 1)) ? '0 : sel + ADDR_NBITS'(1);
    // With nothing valid in IDLE, sel falls back to ptr whose val is 0, so this covers both states.
    assign io.ostream_val = reset & io.istream_val[sel];
    assign io.ostream_msg = io.ostream_val ? {sel, io.istream_msg[sel]} : '0;
    assign io.istream_rdy = (reset & io.ostream_rdy) ? NINPUTS'(1) << sel : '0;
    assign io.grant_idx   = sel;
    assign io.busy        = (state == BURST);
    assign xfer           = io.ostream_val & io.ostream_rdy;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            cnt   <= '0;
        end else if (xfer) begin
            if (state == IDLE) begin
                if (BURST_LEN > 1) begin
                    gnt   <= sel;
                    cnt   <= CNT_NBITS'(1);
                    state <= BURST;
                end else begin
                    ptr <= sel_nxt;
                end
            end else if (cnt == CNT_NBITS'(BURST_LEN - 1)) begin
                state <= IDLE;
                cnt   <= '0;
                ptr   <= sel_nxt;
            end else begin
                cnt <= cnt + CNT_NBITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_arbiter_router_burst_arbiter.sv
// tb_arbiter_router_burst_arbiter: vector table on a BURST_LEN=1 instance plus scoreboarded burst sequences on a BURST_LEN=8 instance.
module tb_arbiter_router_burst_arbiter;
    localparam int NB = 16;
    localparam int NI = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    arbiter_router_burst_arbiter_if #(.NBITS(NB), .NINPUTS(NI)) io8 ();
    arbiter_router_burst_arbiter_if #(.NBITS(NB), .NINPUTS(NI)) io1 ();
    arbiter_router_burst_arbiter #(.NBITS(NB), .NINPUTS(NI), .BURST_LEN(8)) dut8 (
        .clk(clk), .reset(reset), .io(io8.slave)
    );
    arbiter_router_burst_arbiter #(.NBITS(NB), .NINPUTS(NI), .BURST_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .io(io1.slave)
    );
    logic [3:0]  val8 = '0, val1 = '0;
    logic        rdy8 = 1'b1, rdy1 = 1'b1;
    int          beat [NI];
    logic [3:0]  fired;
    logic [17:0] sbq [$];
    int          n_cmp = 0, n_err = 0;
    assign io8.istream_val = val8;
    assign io8.ostream_rdy = rdy8;
    assign io1.istream_val = val1;
    assign io1.ostream_rdy = rdy1;
    // Payload carries the source id and a per-source beat count, so misrouted or reordered data is visible.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            io8.istream_msg[i] = 16'(i * 4096 + beat[i]);
            io1.istream_msg[i] = 16'hA000 | 16'(i);
        end
    end
    typedef struct {
        logic [3:0] val;
        logic       rdy;
        logic       ov;
        logic [1:0] g;
        logic [3:0] irdy;
    } vec_t;
    vec_t tbl [16];
    function automatic logic [17:0] ent(int s, int b);
        return {2'(s), 16'(s * 4096 + b)};
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Called at a negedge with inputs set; scores the beat that the coming posedge commits.
    task automatic tick();
        #1;
        if (io8.ostream_val && io8.ostream_rdy) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected no transfer", io8.ostream_msg);
            end else begin
                check("sb_beat", 32'(io8.ostream_msg), 32'(sbq.pop_front()));
            end
        end
        fired = val8 & io8.istream_rdy;
        @(negedge clk);
        for (int i = 0; i < NI; i++) if (fired[i]) beat[i]++;
    endtask
    task automatic do_reset();
        val8 = 4'hF;
        val1 = 4'hF;
        rdy8 = 1'b1;
        rdy1 = 1'b1;
        reset = 1'b0;
        #1;
        check("rst_val8", io8.ostream_val, 0);
        check("rst_rdy8", io8.istream_rdy, 0);
        check("rst_busy8", io8.busy, 0);
        check("rst_msg8", io8.ostream_msg, 0);
        check("rst_grant8", io8.grant_idx, 0);
        check("rst_val1", io1.ostream_val, 0);
        check("rst_rdy1", io1.istream_rdy, 0);
        @(negedge clk);
        @(negedge clk);
        val8 = '0;
        val1 = '0;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) beat[i] = 0;
        sbq.delete();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        // BURST_LEN=1: every transfer moves ptr to winner+1; an idle row shows ptr on grant_idx.
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0000};
        tbl[2]  = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[3]  = '{4'b1010, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[4]  = '{4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[5]  = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[6]  = '{4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000};
        tbl[8]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[9]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[10] = '{4'b0111, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[11] = '{4'b0111, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[12] = '{4'b0111, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000};
        tbl[14] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        for (int i = 0; i < NI; i++) beat[i] = 0;
        do_reset();
        foreach (tbl[r]) begin
            val1 = tbl[r].val;
            rdy1 = tbl[r].rdy;
            #1;
            check($sformatf("tbl%0d_val", r), io1.ostream_val, tbl[r].ov);
            check($sformatf("tbl%0d_grant", r), io1.grant_idx, tbl[r].g);
            check($sformatf("tbl%0d_rdy", r), io1.istream_rdy, tbl[r].irdy);
            check($sformatf("tbl%0d_busy", r), io1.busy, 0);
            check($sformatf("tbl%0d_msg", r), io1.ostream_msg,
                  tbl[r].ov ? {tbl[r].g, 16'hA000 | 16'(tbl[r].g)} : 18'd0);
            @(negedge clk);
        end
        val1 = '0;
        // Single requester on input 2.
        do_reset();
        for (int b = 0; b < 8; b++) sbq.push_back(ent(2, b));
        val8 = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t1_busy", io8.busy, k != 0);
            tick();
        end
        val8 = '0;
        #1;
        check("t1_busy_end", io8.busy, 0);
        check("t1_ptr", io8.grant_idx, 3);
        check("t1_drain", sbq.size(), 0);
        // All four inputs continuously valid: whole bursts in order 0,1,2,3,0.
        do_reset();
        for (int s = 0; s < 4; s++) for (int b = 0; b < 8; b++) sbq.push_back(ent(s, b));
        for (int b = 8; b < 16; b++) sbq.push_back(ent(0, b));
        val8 = 4'hF;
        n = 0;
        while (sbq.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        val8 = '0;
        check("t2_drain", sbq.size(), 0);
        check("t2_cycles", n, 40);
        // Locked input 1 stalls for five cycles while input 0 waits.
        do_reset();
        for (int b = 0; b < 8; b++) sbq.push_back(ent(1, b));
        sbq.push_back(ent(0, 0));
        val8 = 4'b0010;
        tick();
        val8 = 4'b0011;
        tick();
        tick();
        val8 = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_gap_val", io8.ostream_val, 0);
            check("t3_gap_rdy0", io8.istream_rdy[0], 0);
            check("t3_gap_grant", io8.grant_idx, 1);
            tick();
        end
        val8 = 4'b0011;
        for (int k = 0; k < 5; k++) tick();
        #1;
        check("t3_next_grant", io8.grant_idx, 0);
        check("t3_next_busy", io8.busy, 0);
        tick();
        val8 = '0;
        check("t3_drain", sbq.size(), 0);
        // Backpressure pattern 1,0,0 on input 3's burst.
        do_reset();
        for (int b = 0; b < 8; b++) sbq.push_back(ent(3, b));
        val8 = 4'b1000;
        n = 0;
        while (sbq.size() > 0 && n < 60) begin
            rdy8 = (n % 3 == 0);
            #1;
            if (!rdy8) begin
                check("t4_hold_val", io8.ostream_val, 1);
                check("t4_hold_msg", io8.ostream_msg, sbq[0]);
            end
            tick();
            n++;
        end
        val8 = '0;
        rdy8 = 1'b1;
        #1;
        check("t4_busy_end", io8.busy, 0);
        check("t4_ptr_wrap", io8.grant_idx, 0);
        check("t4_cycles", n, 22);
        check("t4_drain", sbq.size(), 0);
        // Asynchronous reset during beat 5 of input 2's burst.
        do_reset();
        for (int b = 0; b < 4; b++) sbq.push_back(ent(2, b));
        val8 = 4'b0100;
        repeat (4) tick();
        #1;
        check("t5_pre_val", io8.ostream_val, 1);
        check("t5_pre_busy", io8.busy, 1);
        #1 reset = 1'b0;
        #1;
        check("t5_rst_val", io8.ostream_val, 0);
        check("t5_rst_rdy", io8.istream_rdy, 0);
        check("t5_rst_busy", io8.busy, 0);
        check("t5_rst_msg", io8.ostream_msg, 0);
        @(negedge clk);
        val8 = 4'b0110;
        reset = 1'b1;
        #1;
        check("t5_restart_grant", io8.grant_idx, 1);
        check("t5_restart_val", io8.ostream_val, 1);
        sbq.push_back(ent(1, beat[1]));
        tick();
        val8 = '0;
        check("t5_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
